// File: rtl/fv_lv_frame_checker.sv
// Receive-side FV/LV video bus monitor: measures line/frame geometry and timing,
// flags geometry/protocol violations and optionally checks 8-band colour bars.
module fv_lv_frame_checker #(
  parameter int DATA_WIDTH_I = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    fv_i,
  input  logic                    lv_i,
  input  logic [DATA_WIDTH_I-1:0] data_i,
  input  logic [15:0]             exp_width_i,
  input  logic [15:0]             exp_height_i,
  input  logic                    chk_pattern_en_i,
  input  logic                    clear_i,
  output logic [15:0]             width_o,
  output logic [15:0]             line_blank_o,
  output logic [15:0]             height_o,
  output logic [31:0]             fv_high_o,
  output logic [31:0]             frame_period_o,
  output logic [15:0]             frame_count_o,
  output logic                    frame_done_o,
  output logic                    width_err_o,
  output logic                    height_err_o,
  output logic                    pattern_err_o,
  output logic                    protocol_err_o,
  output logic [15:0]             pattern_err_cnt_o
);

  typedef enum logic [1:0] {SYNC, WAIT_FV, IN_FRAME} state_t;

  state_t state, state_nxt;

  logic                    fv_q, lv_q, fv_qq, lv_qq;
  logic [DATA_WIDTH_I-1:0] data_q;
  logic                    pipe_vld;

  logic [15:0] pix_cnt, blank_cnt, line_cnt;
  logic [31:0] fv_cnt, per_cnt;
  logic        first_seen, per_armed;
  logic [12:0] band_pos;
  logic [2:0]  band;

  logic        fv_rise, fv_fall, lv_rise, lv_fall;
  logic        in_frame, frame_start, frame_end, line_end, line_start;
  logic        pix_en, blank_en, fv_en, proto_evt, pat_miss;
  logic [12:0] bw;
  logic [15:0] height_nxt;
  logic [31:0] exp_col32;
  logic [DATA_WIDTH_I-1:0] exp_col;

  function automatic logic [31:0] bar_color(input logic [2:0] b);
    case (b)
      3'd0:    return 32'hff80ff80;
      3'd1:    return 32'hff94ff00;
      3'd2:    return 32'hc81ac8bf;
      3'd3:    return 32'hca4aca55;
      3'd4:    return 32'h96f3969f;
      3'd5:    return 32'h4cff4c54;
      3'd6:    return 32'h409e40d3;
      default: return 32'h00800080;
    endcase
  endfunction

  always_comb begin
    fv_rise     = fv_q & ~fv_qq;
    fv_fall     = ~fv_q & fv_qq;
    lv_rise     = lv_q & ~lv_qq;
    lv_fall     = ~lv_q & lv_qq;
    in_frame    = (state == IN_FRAME);
    frame_start = (state == WAIT_FV) & fv_rise;
    frame_end   = in_frame & fv_fall;
    line_end    = in_frame & lv_fall;
    line_start  = in_frame & fv_q & lv_rise;
    pix_en      = in_frame & fv_q & lv_q;
    blank_en    = in_frame & fv_q & ~lv_q & first_seen;
    fv_en       = fv_q & (state != SYNC);
    proto_evt   = (state != SYNC) & ((lv_q & ~fv_q) | (frame_end & lv_q));
    bw          = exp_width_i[15:3];
    exp_col32   = bar_color(band);
    pat_miss    = chk_pattern_en_i & pix_en & (bw != '0) & (data_q != exp_col);
    // A line ending in the same detect cycle as FV is counted before height latches.
    height_nxt  = line_cnt;
    if (line_end && line_cnt != '1) height_nxt = line_cnt + 16'd1;
  end

  assign exp_col = exp_col32[DATA_WIDTH_I-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      // pipe_vld keeps the reset value of fv_q from being mistaken for a sampled FV low.
      SYNC:     if (pipe_vld && !fv_q) state_nxt = WAIT_FV;
      WAIT_FV:  if (fv_rise) state_nxt = IN_FRAME;
      IN_FRAME: if (fv_fall) state_nxt = WAIT_FV;
      default:  state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= SYNC;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fv_q     <= 1'b0;
      lv_q     <= 1'b0;
      fv_qq    <= 1'b0;
      lv_qq    <= 1'b0;
      data_q   <= '0;
      pipe_vld <= 1'b0;
    end else begin
      fv_q     <= fv_i;
      lv_q     <= lv_i;
      fv_qq    <= fv_q;
      lv_qq    <= lv_q;
      data_q   <= data_i;
      pipe_vld <= 1'b1;
    end
  end

  // Line and frame geometry measurement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_cnt      <= '0;
      blank_cnt    <= '0;
      line_cnt     <= '0;
      fv_cnt       <= '0;
      first_seen   <= 1'b0;
      width_o      <= '0;
      line_blank_o <= '0;
      height_o     <= '0;
      fv_high_o    <= '0;
    end else begin
      if (line_end || frame_end)              pix_cnt <= '0;
      else if (pix_en && pix_cnt != '1)       pix_cnt <= pix_cnt + 16'd1;

      if (line_end) width_o <= pix_cnt;

      if (frame_end)                          line_cnt <= '0;
      else if (line_end && line_cnt != '1)    line_cnt <= line_cnt + 16'd1;

      if (frame_end)       first_seen <= 1'b0;
      else if (line_start) first_seen <= 1'b1;

      if (frame_end || (line_start && first_seen)) blank_cnt <= '0;
      else if (blank_en && blank_cnt != '1)        blank_cnt <= blank_cnt + 16'd1;

      if (line_start && first_seen) line_blank_o <= blank_cnt;

      if (frame_end)                   fv_cnt <= '0;
      else if (fv_en && fv_cnt != '1)  fv_cnt <= fv_cnt + 32'd1;

      if (frame_end) begin
        height_o  <= height_nxt;
        fv_high_o <= fv_cnt;
      end
    end
  end

  // Frame period: the first rise after reset only arms the counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      per_cnt        <= '0;
      per_armed      <= 1'b0;
      frame_period_o <= '0;
    end else if (state == SYNC) begin
      per_cnt   <= '0;
      per_armed <= 1'b0;
    end else if (frame_start) begin
      if (per_armed) frame_period_o <= per_cnt;
      per_cnt   <= 32'd1;
      per_armed <= 1'b1;
    end else if (per_armed && per_cnt != '1) begin
      per_cnt <= per_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      band_pos <= '0;
      band     <= '0;
    end else if (!lv_q) begin
      band_pos <= '0;
      band     <= '0;
    end else if (pix_en && bw != '0) begin
      if (band_pos == bw - 13'd1) begin
        band_pos <= '0;
        if (band != 3'd7) band <= band + 3'd1;
      end else begin
        band_pos <= band_pos + 13'd1;
      end
    end
  end

  // Sticky errors and counters; clear_i overrides any same-cycle set or increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      width_err_o       <= 1'b0;
      height_err_o      <= 1'b0;
      pattern_err_o     <= 1'b0;
      protocol_err_o    <= 1'b0;
      pattern_err_cnt_o <= '0;
      frame_count_o     <= '0;
      frame_done_o      <= 1'b0;
    end else begin
      frame_done_o <= frame_end;
      if (clear_i) begin
        width_err_o       <= 1'b0;
        height_err_o      <= 1'b0;
        pattern_err_o     <= 1'b0;
        protocol_err_o    <= 1'b0;
        pattern_err_cnt_o <= '0;
        frame_count_o     <= '0;
      end else begin
        if (line_end && pix_cnt != exp_width_i)      width_err_o    <= 1'b1;
        if (frame_end && height_nxt != exp_height_i) height_err_o   <= 1'b1;
        if (proto_evt)                               protocol_err_o <= 1'b1;
        if (pat_miss) begin
          pattern_err_o <= 1'b1;
          if (pattern_err_cnt_o != '1) pattern_err_cnt_o <= pattern_err_cnt_o + 16'd1;
        end
        if (frame_end) frame_count_o <= frame_count_o + 16'd1;
      end
    end
  end

endmodule

// File: doc/fv_lv_frame_checker.md
# fv_lv_frame_checker

Receive-side monitor for the parallel FV/LV/data video bus driven by the test-pattern generator or a sensor bridge. It measures line width, line blanking, frame height, FV high time and frame period. It flags geometry and protocol violations and optionally checks pixel data against the 8-band colour-bar pattern. It sits on the video bus ahead of the U3V packetiser and has no effect on the data path.

## Interface
- DATA_WIDTH_I, 32, pixel bus width; pattern check compares the low DATA_WIDTH_I bits of each 32-bit colour constant.
- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- fv_i  in  1  frame valid.
- lv_i  in  1  line valid.
- data_i  in  DATA_WIDTH_I  pixel data, valid while lv_i=1.
- exp_width_i  in  16  expected pixels per line.
- exp_height_i  in  16  expected lines per frame.
- chk_pattern_en_i  in  1  enables the colour-bar compare.
- clear_i  in  1  synchronous clear of sticky errors, error count and frame count.
- width_o  out  16  last completed line length, in pixels.
- line_blank_o  out  16  last LV-low gap between two lines inside FV.
- height_o  out  16  lines in the last frame.
- fv_high_o  out  32  FV high cycles of the last frame.
- frame_period_o  out  32  FV rise-to-rise cycles.
- frame_count_o  out  16  completed frames, wraps at 0xFFFF→0.
- frame_done_o  out  1  one-cycle pulse per completed frame.
- width_err_o, height_err_o, pattern_err_o, protocol_err_o  out  1 each  sticky error flags.
- pattern_err_cnt_o  out  16  pixel mismatches, saturates at 0xFFFF.

## Operation
- **Input pipeline.** Stage 1 registers fv_q, lv_q, data_q. Stage 2 registers fv_qq, lv_qq.
  - Rise = x_q & ~x_qq; fall = ~x_q & x_qq.
  - All logic uses the registered signals only.
- **FSM states:** SYNC, WAIT_FV, IN_FRAME.
  - Reset → SYNC.
  - SYNC → WAIT_FV when fv_q=0. This discards any frame already in progress at reset.
  - WAIT_FV → IN_FRAME on FV rise.
  - IN_FRAME → WAIT_FV on FV fall.
- **pix_cnt (16b, saturating).** Increments while IN_FRAME & fv_q & lv_q.
  - On LV fall: width_o←pix_cnt; line_cnt+1; pix_cnt←0.
  - width_err_o is set if pix_cnt≠exp_width_i.
- **blank_cnt (16b, saturating).** Counts lv_q=0 cycles inside FV after the first line.
  - On an LV rise that is not the first line of the frame: line_blank_o←blank_cnt, then blank_cnt←0.
- **fv_cnt (32b, saturating).** Counts cycles with fv_q=1.
- **On FV fall:**
  - height_o←line_cnt; fv_high_o←fv_cnt; frame_done_o=1 for one cycle; frame_count_o+1.
  - height_err_o is set if line_cnt≠exp_height_i.
  - line_cnt, fv_cnt and first-line flag are then cleared.
- **per_cnt (32b, saturating).** Counts from FV rise.
  - On each FV rise it is latched to frame_period_o and restarted.
  - The first FV rise after reset or SYNC does not latch.
- **Pattern check.** Active when chk_pattern_en_i and lv_q, in IN_FRAME.
  - Band width bw = exp_width_i>>3.
  - band_pos counts 0..bw-1; band (3b) increments on band_pos wrap and saturates at 7.
  - Both band_pos and band reset when lv_q=0.
  - Expected colour per band 0..7: ff80ff80, ff94ff00, c81ac8bf, ca4aca55, 96f3969f, 4cff4c54, 409e40d3, 00800080.
  - On mismatch: pattern_err_o set and pattern_err_cnt_o+1.
  - If bw=0, the check is skipped.
- **Protocol errors.** protocol_err_o is set by either:
  - lv_q=1 while fv_q=0; these cycles are ignored by all counters.
  - FV fall while lv_q=1; the truncated line updates neither width_o nor line_cnt.
- **clear_i.** Clears the four error flags, pattern_err_cnt_o and frame_count_o. Measurements are unaffected.
  - If clear_i coincides with a set event, clear wins.
  - If clear_i coincides with a frame_done increment, the count becomes 0.

## Timing
- Reset value of every output and internal register: 0.
- Input change sampled at clock edge k, meaning x_q changes at edge k. The detect term is true during cycle k→k+1. The corresponding output register updates at edge k+1.
- Measurement and error latency is therefore 2 edges from the input pin.
- frame_done_o is high for exactly the cycle after edge k+1 of the FV fall.
- Simultaneous LV fall and FV fall in the same detect cycle (lv_q and fv_q drop together): treated as a normal line end, with no protocol error. The line is counted before height_o latches.
- Asynchronous reset mid-frame: all state returns to 0 and the FSM enters SYNC. The remainder of the interrupted frame is not measured.
- Saturating counters hold at all-ones; no wrap except frame_count_o.

## Test plan
- **Nominal geometry.** Width 64, height 4, 10 blank cycles before each line inside FV, FV high 296, FV low 100, three frames. Required: width_o=64, line_blank_o=10, height_o=4, fv_high_o=296, frame_period_o=396 after frame 2, frame_count_o=3, no errors.
- **Colour bars.** Same timing, exp_width_i=64, chk_pattern_en_i=1, data = 8 bands of 8 pixels each. Required: pattern_err_cnt_o=0. Corrupting one pixel in band 3 gives count=1 and pattern_err_o=1.
- **Geometry errors.** One 63-pixel line and a 5-line frame. Required: width_err_o=1 and height_err_o=1 two edges after the respective falls; clear_i then clears both.
- **Protocol errors.** LV pulse while FV=0 → protocol_err_o=1 and counters unchanged. FV falling mid-line → protocol_err_o=1 and height_o excludes the truncated line.
- **Reset mid-frame.** Assert reset_n low during line 2 and release while FV=1. Required: all outputs 0, the partial frame is ignored, and the first frame_done_o comes at the end of the next full frame.
